// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // 2'd3 is unused and decodes back to IDLE in the next-state logic.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand and result handshake bundle for serial_subtractor.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );
endinterface

// File: rtl/full_subtractor.sv
// Gate-level one-bit full subtractor: d = x - y - bin, bout = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic xy_diff;
  logic x_n;
  logic xy_same;
  logic borrow_gen;
  logic borrow_prop;

  xor g_half0 (xy_diff, x, y);
  xor g_half1 (d, xy_diff, bin);

  // Borrow is generated when x=0,y=1, or propagated when x==y and a borrow came in.
  not g_xn   (x_n, x);
  not g_same (xy_same, xy_diff);
  and g_gen  (borrow_gen, x_n, y);
  and g_prop (borrow_prop, xy_same, bin);
  or  g_out  (bout, borrow_gen, borrow_prop);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell plus a registered borrow.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_subtractor_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             br_reg;
  logic             bout_reg;
  logic [CW-1:0]    cnt_reg;
  logic             d_bit;
  logic             nb_bit;
  logic             in_ready;
  logic             out_valid;

  full_subtractor u_cell (
    .x    (a_reg[0]),
    .y    (b_reg[0]),
    .bin  (br_reg),
    .d    (d_bit),
    .bout (nb_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid) state_next = SHIFT;
      SHIFT:   if (cnt_reg == LAST) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operands are captured only on the accept edge, so later input changes are invisible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      diff_reg <= '0;
      br_reg   <= 1'b0;
      bout_reg <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg   <= bus.a;
            b_reg   <= bus.b;
            br_reg  <= bus.bin;
            cnt_reg <= '0;
          end
        end
        SHIFT: begin
          diff_reg <= {d_bit, diff_reg[WIDTH-1:1]};
          a_reg    <= a_reg >> 1;
          b_reg    <= b_reg >> 1;
          br_reg   <= nb_bit;
          if (cnt_reg == LAST) begin
            bout_reg <= nb_bit;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.diff      = diff_reg;
  assign bus.bout      = bout_reg;
endmodule
